instruction_fetch_unit: RTL and testbench

Fetch stage that owns the program counter and drives the word address into the synchronous-read instruction memory (1-cycle read latency, no stall input on the memory side). It pairs each returned instruction word with its PC and presents the pair to decode through a valid/ready handshake. A 2-entry output buffer plus credit-based issue means no instruction is lost when decode stalls. Branch/jump redirects flush the stage.

---
 rtl/instruction_fetch_unit.sv | 117 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and fetch stage with 2-entry output buffer and credit-based issue
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] PC_STEP    = 32'd1,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    output logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] ReadData,
    input  logic                  Redirect,
    input  logic [31:0]           RedirectPC,
    output logic                  InstrValid,
    input  logic                  InstrReady,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [31:0]           InstrPC
);

    logic [31:0]           pc_q, pc_d;
    logic [31:0]           req_pc_q, req_pc_d;
    logic                  in_flight_q, in_flight_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [31:0]           epc0_q, epc0_d, epc1_q, epc1_d;
    logic                  pop, push, issue;
    logic [2:0]            occupancy;

    always_comb begin
        pop       = (count_q != 2'd0) && InstrReady;
        // Credits: buffered + in-flight entries, minus the one leaving this cycle.
        occupancy = {1'b0, count_q} + {2'b00, in_flight_q} - {2'b00, pop};
        issue     = Rst_n && !Redirect && (occupancy < 3'd2);
        push      = in_flight_q && !Redirect;

        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        in_flight_d = issue;
        if (Redirect) begin
            pc_d = RedirectPC;
        end else if (issue) begin
            pc_d     = pc_q + PC_STEP;
            req_pc_d = pc_q;
        end

        count_d = count_q;
        data0_d = data0_q;
        epc0_d  = epc0_q;
        data1_d = data1_q;
        epc1_d  = epc1_q;
        if (Redirect) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd0) begin
                        data0_d = ReadData;
                        epc0_d  = req_pc_q;
                    end else begin
                        data1_d = ReadData;
                        epc1_d  = req_pc_q;
                    end
                end
                2'b01: begin
                    count_d = count_q - 2'd1;
                    if (count_q == 2'd2) begin
                        data0_d = data1_q;
                        epc0_d  = epc1_q;
                    end
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        data0_d = ReadData;
                        epc0_d  = req_pc_q;
                    end else begin
                        data0_d = data1_q;
                        epc0_d  = epc1_q;
                        data1_d = ReadData;
                        epc1_d  = req_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'd0;
            in_flight_q <= 1'b0;
            count_q     <= 2'd0;
            data0_q     <= '0;
            epc0_q      <= 32'd0;
            data1_q     <= '0;
            epc1_q      <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            in_flight_q <= in_flight_d;
            count_q     <= count_d;
            data0_q     <= data0_d;
            epc0_q      <= epc0_d;
            data1_q     <= data1_d;
            epc1_q      <= epc1_d;
        end
    end

    assign Address    = pc_q;
    assign InstrValid = (count_q != 2'd0);
    assign Instr      = data0_q;
    assign InstrPC    = epc0_q;

    no_overflow_a: assert property (@(posedge Clk) disable iff (!Rst_n)
        !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] read_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic [31:0] w_address;
    logic [31:0] w_read_data;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'd0;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;

    int          total = 0;
    int          bad = 0;
    int          n_pops = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_next = 32'd0;
    bit          check_count = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .Clk(clk), .Rst_n(rst_n), .Address(address), .ReadData(read_data),
        .Redirect(redirect), .RedirectPC(redirect_pc), .InstrValid(instr_valid),
        .InstrReady(instr_ready), .Instr(instr), .InstrPC(instr_pc)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut_wrap (
        .Clk(clk), .Rst_n(rst_n), .Address(w_address), .ReadData(w_read_data),
        .Redirect(w_redirect), .RedirectPC(w_redirect_pc), .InstrValid(w_valid),
        .InstrReady(w_ready), .Instr(w_instr), .InstrPC(w_instr_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h0021_0820;
            32'd1:   return 32'h0021_1020;
            32'd2:   return 32'h0044_1820;
            default: return {a[15:0] ^ 16'hC3A5, a[15:0]};
        endcase
    endfunction

    // Synchronous-read instruction memories, one cycle latency
    always @(posedge clk) begin
        read_data   <= mem_word(address);
        w_read_data <= mem_word(w_address);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted pair must match the next expected fetch
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_next = 32'd0;
        end else begin
            if (instr_valid && instr_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pop_pc", instr_pc, e.pc);
                    chk("pop_instr", instr, e.data);
                end
            end
            if (redirect) begin
                exp_q.delete();
                exp_next = redirect_pc;
            end
            if (check_count) chk("count_le2", {31'd0, dut.count_q <= 2'd2}, 32'd1);
        end
        while (exp_q.size() < 4) begin
            exp_t n;
            n.pc   = exp_next;
            n.data = mem_word(exp_next);
            exp_q.push_back(n);
            exp_next = exp_next + 32'd1;
        end
    end

    initial begin
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_addr", address, 32'd0);

        // Free run from reset, plus the wrapping instance alongside
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("fr_addr0", address, 32'd0);
        chk("fr_valid0", {31'd0, instr_valid}, 32'd0);
        chk("wr_addr0", w_address, 32'hFFFF_FFFE);
        tick(); @(negedge clk);
        chk("fr_addr1", address, 32'd1);
        chk("fr_valid1", {31'd0, instr_valid}, 32'd0);
        chk("wr_addr1", w_address, 32'hFFFF_FFFF);
        tick(); @(negedge clk);
        chk("fr_valid2", {31'd0, instr_valid}, 32'd1);
        chk("fr_pc2", instr_pc, 32'd0);
        chk("fr_instr2", instr, 32'h0021_0820);
        chk("fr_addr2", address, 32'd2);
        chk("wr_addr2", w_address, 32'd0);
        chk("wr_pc2", w_instr_pc, 32'hFFFF_FFFE);
        tick(); @(negedge clk);
        chk("fr_pc3", instr_pc, 32'd1);
        chk("fr_instr3", instr, 32'h0021_1020);
        chk("wr_pc3", w_instr_pc, 32'hFFFF_FFFF);
        tick(); @(negedge clk);
        chk("fr_pc4", instr_pc, 32'd2);
        chk("fr_instr4", instr, 32'h0044_1820);
        chk("wr_pc4", w_instr_pc, 32'd0);
        chk("wr_instr4", w_instr, mem_word(32'd0));

        // Stall right from the first valid instruction
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; instr_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("st_valid", {31'd0, instr_valid}, 32'd1);
            chk("st_pc", instr_pc, 32'd0);
            chk("st_instr", instr, 32'h0021_0820);
            chk("st_addr", address, 32'd2);
            tick();
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Redirect with full buffer and a pop in the same cycle
        instr_ready = 1'b0;
        tick(); tick();
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'd8;
        tick(); redirect = 1'b0;
        @(negedge clk);
        chk("rd_valid1", {31'd0, instr_valid}, 32'd0);
        chk("rd_addr1", address, 32'd8);
        tick(); @(negedge clk);
        chk("rd_valid2", {31'd0, instr_valid}, 32'd0);
        tick(); @(negedge clk);
        chk("rd_valid3", {31'd0, instr_valid}, 32'd1);
        chk("rd_pc3", instr_pc, 32'd8);
        chk("rd_instr3", instr, mem_word(32'd8));
        for (int i = 0; i < 3; i++) tick();

        // Back-to-back redirects: only the last target is fetched
        redirect = 1'b1; redirect_pc = 32'd40;
        tick(); redirect_pc = 32'd16;
        tick(); redirect = 1'b0;
        tick(); tick(); @(negedge clk);
        chk("bb_pc", instr_pc, 32'd16);
        for (int i = 0; i < 3; i++) tick();

        // Reset mid-stream with a full buffer
        instr_ready = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("mr_full", {30'd0, dut.count_q}, 32'd2);
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("mr_valid", {31'd0, instr_valid}, 32'd0);
        chk("mr_addr", address, 32'd0);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Random back-pressure
        check_count = 1'b1;
        begin
            int start_pops;
            start_pops = n_pops;
            for (int i = 0; i < 1000; i++) begin
                instr_ready = 1'($urandom_range(0, 1));
                tick();
            end
            chk("rand_progress", {31'd0, (n_pops - start_pops) > 300}, 32'd1);
        end
        check_count = 1'b0;

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
